// File: rtl/lb_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the line buffer sequencer.
package lb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int bits_for(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int calc_wpl(input int width);
        return width / 4;
    endfunction

    function automatic int calc_out_rows(input int height, input int kernel_rows);
        return height - kernel_rows + 1;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_wrap_counter.sv
// Modulo-MOD up-counter; wrap flags the increment that returns it to zero.
module wrap_counter
    import lb_ctrl_pkg::*;
#(
    parameter  int MOD = 4,
    localparam int VW  = bits_for(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [VW-1:0] val,
    output logic          wrap
);

    logic [VW-1:0] r_val;
    logic          w_wrap;

    assign w_wrap = inc & (r_val == VW'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_val <= '0;
        end else if (inc) begin
            r_val <= w_wrap ? '0 : r_val + VW'(1);
        end
    end

    assign val  = r_val;
    assign wrap = w_wrap;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Write/read sequencer for a ring of line buffers feeding the SAD kernel.
// Optional stall statistics ports are built when LB_CTRL_STATS_EN is defined.
module line_buffer_ctrl
    import lb_ctrl_pkg::*;
#(
    parameter  int WIDTH       = 740,
    parameter  int NUM_LINES   = 4,
    parameter  int KERNEL_ROWS = 3,
    parameter  int HEIGHT      = 480,
    localparam int LW          = bits_for(NUM_LINES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [NUM_LINES-1:0]      lb_wr_en,
    output logic [31:0]               lb_wr_data,
    output logic [NUM_LINES-1:0]      lb_rd_en,
    output logic [KERNEL_ROWS*LW-1:0] lb_row_sel,
    output logic                      lb_rstn,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last_col,
    output logic                      m_last_row,
    output logic                      frame_done,
    output lb_state_e                 dbg_state
`ifdef LB_CTRL_STATS_EN
    ,
    output logic [31:0]               stall_out_cnt,
    output logic [31:0]               stall_in_cnt
`endif
);

    localparam int WPL      = calc_wpl(WIDTH);
    localparam int OUT_ROWS = calc_out_rows(HEIGHT, KERNEL_ROWS);
    localparam int CW       = bits_for(WPL);
    localparam int FW       = bits_for(NUM_LINES + 1);
    localparam int HW       = bits_for(HEIGHT + 1);

    localparam logic [FW-1:0] C_NUM_LINES = FW'(NUM_LINES);
    localparam logic [FW-1:0] C_KROWS     = FW'(KERNEL_ROWS);
    localparam logic [HW-1:0] C_HEIGHT    = HW'(HEIGHT);
    localparam logic [HW-1:0] C_LAST_ROW  = HW'(OUT_ROWS - 1);
    localparam logic [CW-1:0] C_LAST_COL  = CW'(WPL - 1);

    lb_state_e     r_state, w_next;
    logic [FW-1:0] r_filled;
    logic [HW-1:0] r_lines_written, r_out_row;
    logic [CW-1:0] w_wr_col, w_rd_col;
    logic [LW-1:0] w_wr_line, w_rd_top;
    logic          w_run, w_clr, w_accept, w_beat, w_line_done, w_row_done;
    logic          w_unused_wr_line_wrap, w_unused_rd_top_wrap;

    // Both sides use valid/ready: a word moves on a rising edge only when
    // valid and ready are high together; valid never waits on ready.
    assign w_run    = (r_state == RUN);
    assign w_clr    = (r_state == DONE);
    assign s_ready  = w_run & (r_filled < C_NUM_LINES) & (r_lines_written < C_HEIGHT);
    assign w_accept = s_valid & s_ready;
    assign m_valid  = w_run & (r_filled >= C_KROWS);
    assign w_beat   = m_valid & m_ready;

    assign m_last_col = m_valid & (w_rd_col == C_LAST_COL);
    assign m_last_row = m_valid & (r_out_row == C_LAST_ROW);
    assign lb_wr_data = s_data;
    assign dbg_state  = r_state;

    wrap_counter #(.MOD(WPL)) u_wr_col (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_accept),
        .val(w_wr_col), .wrap(w_line_done)
    );
    wrap_counter #(.MOD(NUM_LINES)) u_wr_line (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_line_done),
        .val(w_wr_line), .wrap(w_unused_wr_line_wrap)
    );
    wrap_counter #(.MOD(WPL)) u_rd_col (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_beat),
        .val(w_rd_col), .wrap(w_row_done)
    );
    wrap_counter #(.MOD(NUM_LINES)) u_rd_top (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_row_done),
        .val(w_rd_top), .wrap(w_unused_rd_top_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        lb_rstn    = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: w_next = RUN;
            RUN: begin
                lb_rstn = 1'b1;
                if (w_beat && m_last_col && m_last_row) w_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A line finishing on the same edge a row retires leaves the fill level alone.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_filled        <= '0;
            r_lines_written <= '0;
            r_out_row       <= '0;
        end else begin
            if (w_line_done && !w_row_done)      r_filled <= r_filled + FW'(1);
            else if (!w_line_done && w_row_done) r_filled <= r_filled - FW'(1);
            if (w_line_done) r_lines_written <= r_lines_written + HW'(1);
            if (w_row_done)  r_out_row <= r_out_row + HW'(1);
        end
    end

    always_comb begin
        logic [LW-1:0] v_line;
        v_line     = '0;
        lb_wr_en   = '0;
        lb_rd_en   = '0;
        lb_row_sel = '0;
        if (w_accept) lb_wr_en[w_wr_line] = 1'b1;
        for (int k = 0; k < KERNEL_ROWS; k++) begin
            v_line = LW'((int'(w_rd_top) + k) % NUM_LINES);
            if (w_beat) lb_rd_en[v_line] = 1'b1;
            if (w_run)  lb_row_sel[k*LW +: LW] = v_line;
        end
    end

`ifdef LB_CTRL_STATS_EN
    logic [31:0] r_stall_out, r_stall_in;

    // Saturating; deliberately survives frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_out <= '0;
            r_stall_in  <= '0;
        end else begin
            if (m_valid && !m_ready && (r_stall_out != '1))
                r_stall_out <= r_stall_out + 32'd1;
            if (w_run && s_valid && !s_ready && (r_stall_in != '1))
                r_stall_in <= r_stall_in + 32'd1;
        end
    end

    assign stall_out_cnt = r_stall_out;
    assign stall_in_cnt  = r_stall_in;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl at WIDTH=16, NUM_LINES=4, KERNEL_ROWS=3, HEIGHT=6.
module tb_line_buffer_ctrl;
    import lb_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  lb_wr_en;
    logic [31:0] lb_wr_data;
    logic [3:0]  lb_rd_en;
    logic [5:0]  lb_row_sel;
    logic        lb_rstn, m_valid, m_last_col, m_last_row, frame_done;
    logic        m_ready = 1'b1;
    lb_state_e   dbg_state;

    line_buffer_ctrl #(
        .WIDTH(16), .NUM_LINES(4), .KERNEL_ROWS(3), .HEIGHT(6)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .lb_wr_en(lb_wr_en), .lb_wr_data(lb_wr_data),
        .lb_rd_en(lb_rd_en), .lb_row_sel(lb_row_sel), .lb_rstn(lb_rstn),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_last_col(m_last_col), .m_last_row(m_last_row),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  beat_cnt = 0;
    int  last_beat_cyc = 0;
    bit  mon_en = 1'b0;

    logic [35:0] exp_wr_q[$];
    logic [11:0] exp_beat_q[$];

    // Hand-computed per-row window placement for a 4-line ring, 3 kernel rows.
    logic [5:0] sel_t[4]  = '{6'h24, 6'h39, 6'h0E, 6'h13};
    logic [3:0] rden_t[4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [35:0] ew;
        logic [11:0] eb;
        if (mon_en) begin
            if (s_valid && s_ready) begin
                if (exp_wr_q.size() == 0) fail_now("wr_unexpected");
                else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_word", 64'({lb_wr_en, lb_wr_data}), 64'(ew));
                end
            end else begin
                chk("wr_idle", 64'(lb_wr_en), 64'd0);
            end
            if (m_valid && m_ready) begin
                beat_cnt++;
                last_beat_cyc = cyc;
                if (exp_beat_q.size() == 0) fail_now("beat_unexpected");
                else begin
                    eb = exp_beat_q.pop_front();
                    chk("beat", 64'({lb_row_sel, lb_rd_en, m_last_col, m_last_row}), 64'(eb));
                end
            end else begin
                chk("rd_idle", 64'(lb_rd_en), 64'd0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++)
            exp_wr_q.push_back({4'b0001 << ((i / 4) % 4), word_of(i)});
    endtask

    task automatic push_beats(input int n);
        for (int b = 0; b < n; b++)
            exp_beat_q.push_back({sel_t[b / 4], rden_t[b / 4], (b % 4) == 3, (b / 4) == 3});
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_words(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int t;
            acc = 1'b0;
            t = 0;
            s_data  = word_of(start + i);
            s_valid = 1'b1;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                fail_now("send_timeout");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic run_frame();
        int  base;
        bit  found;
        push_writes(24);
        push_beats(16);
        base = beat_cnt;
        send_words(11, 0);
        fork
            send_words(1, 11);
            begin
                @(negedge clk);
                chk("fill_mvalid_low", 64'(m_valid), 64'd0);
                chk("run_lb_rstn", 64'(lb_rstn), 64'd1);
            end
        join
        fork
            send_words(4, 12);
            begin
                @(negedge clk);
                chk("fill_mvalid", 64'(m_valid), 64'd1);
                chk("fill_row_sel", 64'(lb_row_sel), 64'h24);
                chk("fill_rd_en", 64'(lb_rd_en), 64'b0111);
            end
        join
        fork
            send_words(8, 16);
            begin
                @(negedge clk);
                chk("simul_mvalid", 64'(m_valid), 64'd1);
                chk("simul_row_sel", 64'(lb_row_sel), 64'h39);
            end
        join
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            found = frame_done;
        end
        chk("frame_done_seen", 64'(found), 64'd1);
        chk("frame_beats", 64'(beat_cnt - base), 64'd16);
        chk("done_latency", 64'(cyc - last_beat_cyc), 64'd1);
        chk("done_lb_rstn", 64'(lb_rstn), 64'd0);
        chk("done_mvalid", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(frame_done), 64'd0);
        chk("frame_wr_left", 64'(exp_wr_q.size()), 64'd0);
        chk("frame_beat_left", 64'(exp_beat_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int t;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_wr_en", 64'(lb_wr_en), 64'd0);
        chk("rst_rd_en", 64'(lb_rd_en), 64'd0);
        chk("rst_row_sel", 64'(lb_row_sel), 64'd0);
        chk("rst_last", 64'({m_last_col, m_last_row}), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_lb_rstn", 64'(lb_rstn), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Full frame, then a second frame straight after frame_done.
        run_frame();
        run_frame();

        // Backpressure with the SAD core stalled.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b0;
        push_writes(16);
        send_words(16, 0);
        s_data  = word_of(16);
        s_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;

        // Release, then reset while beat 6 (row 1, col 2) is on the bus.
        push_beats(7);
        base = beat_cnt;
        m_ready = 1'b1;
        t = 0;
        while ((beat_cnt - base) < 6 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pre_reset_beats", 64'(beat_cnt - base), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_lb_rstn", 64'(lb_rstn), 64'd0);
        chk("mid_rst_no_done", 64'(frame_done), 64'd0);
        chk("mid_rst_beats_left", 64'(exp_beat_q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh frame after the abort fills exactly like the first.
        push_writes(12);
        push_beats(4);
        send_words(11, 0);
        fork
            send_words(1, 11);
            begin
                @(negedge clk);
                chk("refill_mvalid_low", 64'(m_valid), 64'd0);
            end
        join
        @(negedge clk);
        chk("refill_mvalid", 64'(m_valid), 64'd1);
        chk("refill_row_sel", 64'(lb_row_sel), 64'h24);
        chk("refill_rd_en", 64'(lb_rd_en), 64'b0111);
        repeat (10) @(negedge clk);
        chk("refill_drained", 64'(m_valid), 64'd0);
        chk("refill_no_done", 64'(frame_done), 64'd0);
        chk("end_wr_left", 64'(exp_wr_q.size()), 64'd0);
        chk("end_beat_left", 64'(exp_beat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
